// File: rtl/simple_interconnect_initiator.sv
// Initiator end of the simple interconnect bus: command port, write-data FIFO,
// bus sequencing FSM and a two-stage read-return pipeline.
module simple_interconnect_initiator #(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 3,
    parameter int LEN_W       = 3,
    parameter int WFIFO_DEPTH = 8,
    localparam int CW = $clog2(WFIFO_DEPTH) + 1,
    localparam int PW = $clog2(WFIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wfifo_push,
    input  logic [DATA_W-1:0] wfifo_data,
    output logic [CW-1:0]     wfifo_count,
    output logic              wfifo_full,
    output logic              wfifo_ovf,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              cmd_err,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic              wr,
    output logic              rd,
    output logic [LEN_W-1:0]  length,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);
    typedef enum logic [1:0] {S_IDLE, S_WAITW, S_APHASE, S_DATA} state_t;

    state_t            state, state_d;
    logic              l_wr;
    logic [ADDR_W-1:0] l_addr;
    logic [LEN_W-1:0]  l_len;
    logic [LEN_W-1:0]  beat_cnt, beat_d;
    logic [DATA_W-1:0] mem [WFIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count_d;
    logic              s1_v, s1_last, s1_v_d, s1_last_d;

    logic              accept, lat_en, pop, push_ok, busy_d;
    logic              eff_wr;
    logic [ADDR_W-1:0] eff_addr, addr_d;
    logic [LEN_W-1:0]  eff_len, len_d;
    logic              wr_d, rd_d;
    logic [DATA_W-1:0] wdata_d;

    // Command handshake: a command transfers on a rising edge where cmd_valid
    // and cmd_ready are both high; cmd_ready is high only while idle.
    always_comb begin
        accept    = cmd_valid && cmd_ready;
        lat_en    = 1'b0;
        state_d   = state;
        beat_d    = beat_cnt;
        case (state)
            S_IDLE: begin
                if (accept && cmd_len != '0) begin
                    lat_en = 1'b1;
                    if (!cmd_wr || wfifo_count >= CW'(cmd_len)) state_d = S_APHASE;
                    else                                         state_d = S_WAITW;
                end
            end
            S_WAITW:  if (wfifo_count >= CW'(l_len)) state_d = S_APHASE;
            S_APHASE: begin
                state_d = S_DATA;
                beat_d  = l_len;
            end
            S_DATA: begin
                beat_d = beat_cnt - LEN_W'(1);
                if (beat_cnt == LEN_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        eff_wr   = lat_en ? cmd_wr   : l_wr;
        eff_addr = lat_en ? cmd_addr : l_addr;
        eff_len  = lat_en ? cmd_len  : l_len;

        // Bus outputs are registered, so they are derived from the next state.
        addr_d  = '0;
        len_d   = '0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        wdata_d = '0;
        pop     = 1'b0;
        if (state_d == S_APHASE) begin
            addr_d = eff_addr;
            len_d  = eff_len;
            wr_d   = eff_wr;
            rd_d   = !eff_wr;
        end else if (state_d == S_DATA) begin
            addr_d = l_addr;
            if (l_wr) begin
                wdata_d = mem[rd_ptr];
                pop     = 1'b1;
            end
        end

        push_ok   = wfifo_push && !wfifo_full;
        count_d   = wfifo_count + CW'(push_ok) - CW'(pop);
        s1_v_d    = (state == S_DATA) && !l_wr;
        s1_last_d = s1_v_d && (beat_cnt == LEN_W'(1));
        busy_d    = (state_d != S_IDLE) || s1_v_d || s1_v;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            l_wr        <= 1'b0;
            l_addr      <= '0;
            l_len       <= '0;
            beat_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wfifo_count <= '0;
            wfifo_full  <= 1'b0;
            wfifo_ovf   <= 1'b0;
            s1_v        <= 1'b0;
            s1_last     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_last     <= 1'b0;
            rd_data     <= '0;
            cmd_ready   <= 1'b0;
            cmd_err     <= 1'b0;
            busy        <= 1'b0;
            address     <= '0;
            wr          <= 1'b0;
            rd          <= 1'b0;
            length      <= '0;
            wdata       <= '0;
        end else begin
            state    <= state_d;
            beat_cnt <= beat_d;
            if (lat_en) begin
                l_wr   <= cmd_wr;
                l_addr <= cmd_addr;
                l_len  <= cmd_len;
            end
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            wfifo_count <= count_d;
            wfifo_full  <= (count_d == CW'(WFIFO_DEPTH));
            wfifo_ovf   <= wfifo_push && wfifo_full;
            // rdata lags a data beat by one cycle; capture it one cycle later.
            s1_v     <= s1_v_d;
            s1_last  <= s1_last_d;
            rd_valid <= s1_v;
            rd_last  <= s1_v && s1_last;
            rd_data  <= s1_v ? rdata : '0;
            cmd_ready <= (state_d == S_IDLE);
            cmd_err   <= accept && (cmd_len == '0);
            busy      <= busy_d;
            address   <= addr_d;
            wr        <= wr_d;
            rd        <= rd_d;
            length    <= len_d;
            wdata     <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wfifo_data;
    end
endmodule

// File: tb/tb_simple_interconnect_initiator.sv
// Directed bench for simple_interconnect_initiator with a small peripheral model
// that latches bursts on wr/rd and returns registered rdata.
module tb_simple_interconnect_initiator;
    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [2:0] cmd_addr, cmd_len;
    logic       wfifo_push;
    logic [3:0] wfifo_data, wfifo_count;
    logic       wfifo_full, wfifo_ovf;
    logic       rd_valid, rd_last, cmd_err, busy;
    logic [3:0] rd_data, wdata, rdata;
    logic [2:0] address, length;
    logic       wr, rd;

    int tests_run    = 0;
    int tests_failed = 0;

    simple_interconnect_initiator dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wfifo_push(wfifo_push), .wfifo_data(wfifo_data),
        .wfifo_count(wfifo_count), .wfifo_full(wfifo_full), .wfifo_ovf(wfifo_ovf),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .cmd_err(cmd_err), .busy(busy),
        .address(address), .wr(wr), .rd(rd), .length(length),
        .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Bus view {wr, rd, length, address, wdata} and the full output vector.
    logic [11:0] bus;
    logic [26:0] all_out;
    assign bus     = {wr, rd, length, address, wdata};
    assign all_out = {cmd_ready, wfifo_count, wfifo_full, wfifo_ovf, rd_valid, rd_data,
                      rd_last, cmd_err, busy, address, wr, rd, length, wdata};

    // Peripheral model; memory resets to mem[i] = 15 - i.
    logic [3:0] p_mem [8];
    logic [2:0] p_addr, p_cnt;
    logic       p_wr;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_addr <= '0;
            p_cnt  <= '0;
            p_wr   <= 1'b0;
            rdata  <= '0;
            for (int i = 0; i < 8; i++) p_mem[i] <= 4'(15 - i);
        end else if (wr || rd) begin
            p_addr <= address;
            p_cnt  <= length;
            p_wr   <= wr;
        end else if (p_cnt != 0) begin
            if (p_wr) p_mem[p_addr] <= wdata;
            else      rdata <= p_mem[p_addr];
            p_addr <= p_addr + 3'd1;
            p_cnt  <= p_cnt - 3'd1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] d);
        wfifo_push = 1'b1;
        wfifo_data = d;
        tick();
        wfifo_push = 1'b0;
    endtask

    // Returns at the negedge after the accepting edge.
    task automatic issue(input logic w, input logic [2:0] a, input logic [2:0] l);
        cmd_valid = 1'b1;
        cmd_wr    = w;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        tests_run++;
        if (all_out !== '0) begin
            tests_failed++; $display("FAIL reset_outputs: got %h exp 0", all_out);
        end
        tick();
        resetn = 1'b1;
        tick();
        tests_run++;
        if ({cmd_ready, busy, wfifo_count} !== {1'b1, 1'b0, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_release: ready/busy/count got %b/%b/%0d exp 1/0/0", cmd_ready, busy, wfifo_count);
        end
    endtask

    task automatic test_write_read();
        logic [3:0] exp_d [3];
        exp_d[0] = 4'hA; exp_d[1] = 4'h9; exp_d[2] = 4'h8;
        push(4'hA);
        issue(1'b1, 3'd5, 3'd1);
        tests_run++;
        if (bus !== {1'b1, 1'b0, 3'd1, 3'd5, 4'h0}) begin
            tests_failed++; $display("FAIL wr1_aphase: got %h exp %h", bus, {1'b1, 1'b0, 3'd1, 3'd5, 4'h0});
        end
        tick();
        tests_run++;
        if (bus !== {1'b0, 1'b0, 3'd0, 3'd5, 4'hA}) begin
            tests_failed++; $display("FAIL wr1_data: got %h exp %h", bus, {1'b0, 1'b0, 3'd0, 3'd5, 4'hA});
        end
        tick();
        issue(1'b0, 3'd5, 3'd3);
        tests_run++;
        if (bus !== {1'b0, 1'b1, 3'd3, 3'd5, 4'h0}) begin
            tests_failed++; $display("FAIL rd3_aphase: got %h exp %h", bus, {1'b0, 1'b1, 3'd3, 3'd5, 4'h0});
        end
        for (int t = 1; t <= 6; t++) begin
            tick();
            tests_run++;
            if (t >= 3 && t <= 5) begin
                if ({rd_valid, rd_data, rd_last} !== {1'b1, exp_d[t-3], (t == 5)}) begin
                    tests_failed++;
                    $display("FAIL rd3_beat t=%0d: v/d/l got %b/%h/%b exp 1/%h/%b", t, rd_valid, rd_data, rd_last, exp_d[t-3], (t == 5));
                end
            end else if (rd_valid !== 1'b0) begin
                tests_failed++; $display("FAIL rd3_novalid t=%0d: rd_valid got %b exp 0", t, rd_valid);
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL rd3_idle: busy got %b exp 0", busy);
        end
    endtask

    task automatic test_burst_write();
        for (int i = 1; i <= 4; i++) push(4'(i));
        tests_run++;
        if (wfifo_count !== 4'd4) begin
            tests_failed++; $display("FAIL bw_count_pre: got %0d exp 4", wfifo_count);
        end
        issue(1'b1, 3'd0, 3'd4);
        tests_run++;
        if (bus !== {1'b1, 1'b0, 3'd4, 3'd0, 4'h0}) begin
            tests_failed++; $display("FAIL bw_aphase: got %h exp %h", bus, {1'b1, 1'b0, 3'd4, 3'd0, 4'h0});
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++;
            if (bus !== {1'b0, 1'b0, 3'd0, 3'd0, 4'(i)}) begin
                tests_failed++; $display("FAIL bw_data%0d: got %h exp %h", i, bus, {1'b0, 1'b0, 3'd0, 3'd0, 4'(i)});
            end
        end
        tests_run++;
        if (wfifo_count !== 4'd0) begin
            tests_failed++; $display("FAIL bw_count_post: got %0d exp 0", wfifo_count);
        end
        tick();
        issue(1'b0, 3'd3, 3'd1);
        tick();
        tick();
        tick();
        tests_run++;
        if ({rd_valid, rd_data, rd_last} !== {1'b1, 4'h4, 1'b1}) begin
            tests_failed++; $display("FAIL bw_readback: v/d/l got %b/%h/%b exp 1/4/1", rd_valid, rd_data, rd_last);
        end
    endtask

    task automatic test_waitw();
        push(4'h5);
        push(4'h6);
        issue(1'b1, 3'd2, 3'd3);
        tests_run++;
        if ({bus, cmd_ready, busy} !== {12'h000, 1'b0, 1'b1}) begin
            tests_failed++; $display("FAIL waitw_idle_bus: bus/ready/busy got %h/%b/%b exp 000/0/1", bus, cmd_ready, busy);
        end
        push(4'h7);
        tests_run++;
        if ({bus, wfifo_count} !== {12'h000, 4'd3}) begin
            tests_failed++; $display("FAIL waitw_count3: bus/count got %h/%0d exp 000/3", bus, wfifo_count);
        end
        tick();
        tests_run++;
        if (bus !== {1'b1, 1'b0, 3'd3, 3'd2, 4'h0}) begin
            tests_failed++; $display("FAIL waitw_aphase: got %h exp %h", bus, {1'b1, 1'b0, 3'd3, 3'd2, 4'h0});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (wdata !== 4'(5 + i)) begin
                tests_failed++; $display("FAIL waitw_data%0d: got %h exp %h", i, wdata, 4'(5 + i));
            end
        end
        tick();
    endtask

    task automatic test_len0();
        issue(1'b1, 3'd1, 3'd0);
        tests_run++;
        if ({cmd_err, wr, rd, busy, cmd_ready} !== 5'b10001) begin
            tests_failed++; $display("FAIL len0_err: err/wr/rd/busy/ready got %b exp 10001", {cmd_err, wr, rd, busy, cmd_ready});
        end
        tick();
        tests_run++;
        if ({cmd_err, wr, rd, busy} !== 4'b0000) begin
            tests_failed++; $display("FAIL len0_after: err/wr/rd/busy got %b exp 0000", {cmd_err, wr, rd, busy});
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) push(4'(i));
        tests_run++;
        if ({wfifo_full, wfifo_ovf, wfifo_count} !== {1'b1, 1'b0, 4'd8}) begin
            tests_failed++; $display("FAIL ovf_full8: full/ovf/count got %b/%b/%0d exp 1/0/8", wfifo_full, wfifo_ovf, wfifo_count);
        end
        push(4'hF);
        tests_run++;
        if ({wfifo_full, wfifo_ovf, wfifo_count} !== {1'b1, 1'b1, 4'd8}) begin
            tests_failed++; $display("FAIL ovf_drop: full/ovf/count got %b/%b/%0d exp 1/1/8", wfifo_full, wfifo_ovf, wfifo_count);
        end
        tick();
        tests_run++;
        if (wfifo_ovf !== 1'b0) begin
            tests_failed++; $display("FAIL ovf_pulse: got %b exp 0", wfifo_ovf);
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'd0, 3'd5);
        tick();
        tick();
        #2 resetn = 1'b0;
        #1;
        tests_run++;
        if (all_out !== '0) begin
            tests_failed++; $display("FAIL midreset_outputs: got %h exp 0", all_out);
        end
        tick();
        tick();
        resetn = 1'b1;
        tick();
        tests_run++;
        if ({cmd_ready, wfifo_count} !== {1'b1, 4'd0}) begin
            tests_failed++; $display("FAIL midreset_release: ready/count got %b/%0d exp 1/0", cmd_ready, wfifo_count);
        end
        for (int t = 0; t < 6; t++) begin
            tick();
            tests_run++;
            if (rd_valid !== 1'b0) begin
                tests_failed++; $display("FAIL midreset_novalid t=%0d: got %b exp 0", t, rd_valid);
            end
        end
    endtask

    initial begin
        resetn     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_wr     = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        wfifo_push = 1'b0;
        wfifo_data = '0;
        test_reset();
        test_write_read();
        test_burst_write();
        test_waitw();
        test_len0();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
